usb_out_arbiter: RTL and testbench
==================================

# usb_out_arbiter

Round-robin packet arbiter that shares the single FPGA -> EZ-USB output stream of `ezusb_io` between four 16-bit sources, such as the BRAM FIFO readout, the test-data generator and status channels. It grants one source per burst and prefixes every burst with a header word identifying the channel. A burst ends on the source's `last` flag or when it reaches a maximum length. Its output register drives `ezusb_io` `DI`/`DI_valid`/`DI_ready` directly and obeys the same hold rule.

## Interface
- `MAX_BURST`, default 256: maximum data words per burst, excluding the header; legal range 1..65535.
- `HDR_TAG`, default 8'hA5: upper byte of the header word.

Ports (clock and reset first):
- `ifclk`  in  1: interface clock; all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `src_data`  in  64: channel n data in bits [16n+15:16n].
- `src_valid`  in  4: per-channel word valid.
- `src_last`  in  4: per-channel last word of packet; qualified by `src_valid`.
- `src_ready`  out  4: per-channel word accepted this cycle (combinational).
- `ch_enable`  in  4: channel may be granted; sampled only at arbitration.
- `DI`  out  16: data to `ezusb_io`.
- `DI_valid`  out  1: `DI` valid.
- `DI_ready`  in  1: `ezusb_io` accepts `DI` this cycle.
- `busy`  out  1: a burst is in progress (state DATA).
- `cur_ch`  out  2: granted channel; valid while `busy`.
- `burst_done`  out  1: one-cycle pulse on the cycle the final data word of a burst is accepted from the source.

## Operation
- Output register `DI`/`DI_valid`: the slot is free when `!DI_valid || DI_ready`.
  - When the slot is free and a word is loaded, `DI_valid` goes to 1.
  - When the slot is free and nothing is loaded, `DI_valid` goes to 0.
  - When `DI_valid=1` and `DI_ready=0`, `DI` and `DI_valid` hold.
- Request vector: `req = src_valid & ch_enable`.
- State IDLE:
  - If `req != 0` and the slot is free, grant the first requesting channel searching from `rr_ptr+1` mod 4.
  - On that edge: load header `{HDR_TAG, 6'd0, ch}` into `DI`, set `cur_ch=ch`, `rr_ptr=ch`, `cnt=0`, go to DATA.
  - Otherwise stay in IDLE.
- State DATA:
  - `src_ready[cur_ch] = slot free`; all other `src_ready` bits are 0.
  - On acceptance (`src_valid[cur_ch] && src_ready[cur_ch]`): load the word into `DI` and increment `cnt`.
  - The burst ends on an accepted word when `src_last[cur_ch]=1` or `cnt+1 == MAX_BURST`. On that edge: `burst_done=1` and the state returns to IDLE.
- A burst cut by `MAX_BURST` without `last` is not an error. The source is re-arbitrated later, and its next burst gets a fresh header.
- Clearing `ch_enable` mid-burst has no effect until the burst ends.
- `src_valid` dropping mid-burst stalls the burst. There is no timeout; the grant is held.
- `cnt` width is ceil(log2(MAX_BURST+1)); it never wraps, because the burst ends at `MAX_BURST`.
- `src_ready` is 0 in IDLE. A channel whose `src_valid` is high is never accepted outside its own grant.
- Reset values (asynchronous, on `reset_n=0`): state IDLE, `DI=16'h0000`, `DI_valid=0`, `busy=0`, `cur_ch=0`, `burst_done=0`, `rr_ptr=3` (channel 0 wins first), `cnt=0`, `src_ready=0`.
- Reset asserted mid-burst discards the registered word. No partial-burst recovery is performed; downstream resynchronises on the next header.

## Timing
- Grant latency: request in IDLE with slot free at edge k -> header on `DI` with `DI_valid=1` after edge k.
- First data word: with `src_valid` held and `DI_ready=1` continuously, it is accepted in the cycle after the header is loaded and appears on `DI` after edge k+1.
- Throughput: one word per clock within a burst.
- Per-burst overhead: exactly one header cycle plus at least one IDLE cycle. The IDLE cycle is the cycle after `burst_done`, in which arbitration happens.
- `burst_done` is asserted combinationally with the final acceptance and is deasserted the next cycle.
- `src_ready` depends combinationally on `DI_ready` and `DI_valid`; sources must not feed `src_ready` back into `src_valid` combinationally.

## Test plan
- Reset release; channel 0 sends a 3-word packet 0x0001..0x0003 with `last` on the third word; `DI_ready=1` -> `DI` sequence 0xA500, 0x0001, 0x0002, 0x0003; one `burst_done` pulse; `busy` returns to 0.
- All four channels hold `valid` with 1-word packets -> headers appear in order 0xA500, 0xA501, 0xA502, 0xA503, 0xA500; no channel is granted twice in a row while others request.
- `MAX_BURST=4`; channel 1 streams 10 words without `last` -> bursts of 4+4+2 words, each preceded by 0xA501; the final burst ends on `last`.
- `DI_ready` toggled 1,0,0,1 mid-burst -> `DI`/`DI_valid` stable while `DI_ready=0`; `src_ready[cur_ch]=0` during the stall; no word is lost or duplicated; a scoreboard matches the source sequence.
- `ch_enable=4'b1101` with channel 1 valid -> channel 1 is never granted; clearing `ch_enable[0]` during a channel-0 burst still completes that burst.
- `reset_n` pulsed low mid-burst -> `DI_valid=0` and `busy=0` immediately (asynchronous); after release, channel 0 is granted first.

Source files
------------

// File: rtl/usb_out_arbiter.sv
// Round-robin burst arbiter: four 16-bit sources share one ezusb_io output stream.
// Every burst is preceded by a header word {HDR_TAG, 6'd0, channel}.
module usb_out_arbiter #(
  parameter int         MAX_BURST = 256,
  parameter logic [7:0] HDR_TAG   = 8'hA5
) (
  input  logic        ifclk,
  input  logic        reset_n,
  input  logic [63:0] src_data,
  input  logic [3:0]  src_valid,
  input  logic [3:0]  src_last,
  output logic [3:0]  src_ready,
  input  logic [3:0]  ch_enable,
  output logic [15:0] DI,
  output logic        DI_valid,
  input  logic        DI_ready,
  output logic        busy,
  output logic [1:0]  cur_ch,
  output logic        burst_done
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, DATA} state_t;

  state_t        state;
  logic [1:0]    rr_ptr;
  logic [CW-1:0] cnt;

  logic          slot_free;
  logic [3:0]    req;
  logic          grant_any;
  logic [1:0]    grant_ch;
  logic [1:0]    idx;
  logic [15:0]   cur_data;
  logic          cur_valid;
  logic          cur_last;
  logic          accept;
  logic          burst_end;

  assign slot_free = !DI_valid || DI_ready;
  assign req       = src_valid & ch_enable;
  assign busy      = (state == DATA);

  assign cur_data  = src_data[{cur_ch, 4'b0000} +: 16];
  assign cur_valid = src_valid[cur_ch];
  assign cur_last  = src_last[cur_ch];

  // Only the granted channel ever sees ready, and only while the output slot can take a word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ready
      assign src_ready[gi] = (state == DATA) && (cur_ch == 2'(gi)) && slot_free;
    end
  endgenerate

  assign accept     = (state == DATA) && cur_valid && slot_free;
  assign burst_end  = accept && (cur_last || (cnt == CW'(MAX_BURST - 1)));
  assign burst_done = burst_end;

  // Search starts just after the last granted channel; i=4 wraps back to rr_ptr itself.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = rr_ptr;
    idx       = rr_ptr;
    for (int i = 1; i <= 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      DI       <= 16'h0000;
      DI_valid <= 1'b0;
      cur_ch   <= 2'd0;
      rr_ptr   <= 2'd3;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any && slot_free) begin
            DI       <= {HDR_TAG, 6'd0, grant_ch};
            DI_valid <= 1'b1;
            cur_ch   <= grant_ch;
            rr_ptr   <= grant_ch;
            cnt      <= '0;
            state    <= DATA;
          end else if (slot_free) begin
            DI_valid <= 1'b0;
          end
        end
        DATA: begin
          if (accept) begin
            DI       <= cur_data;
            DI_valid <= 1'b1;
            cnt      <= cnt + 1'b1;
            if (burst_end) begin
              state <= IDLE;
            end
          end else if (slot_free) begin
            DI_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_out_arbiter.sv
// Scoreboard bench for usb_out_arbiter: a queue-based round-robin model predicts the
// DI word stream per phase; an independent monitor pops and compares each transfer.
module tb_usb_out_arbiter;

  localparam int         MB  = 4;
  localparam logic [7:0] HDR = 8'hA5;

  logic        ifclk = 1'b0;
  logic        reset_n;
  logic [63:0] src_data;
  logic [3:0]  src_valid;
  logic [3:0]  src_last;
  logic [3:0]  src_ready;
  logic [3:0]  ch_enable;
  logic [15:0] DI;
  logic        DI_valid;
  logic        DI_ready;
  logic        busy;
  logic [1:0]  cur_ch;
  logic        burst_done;

  usb_out_arbiter #(.MAX_BURST(MB), .HDR_TAG(HDR)) dut (
    .ifclk(ifclk), .reset_n(reset_n),
    .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
    .ch_enable(ch_enable),
    .DI(DI), .DI_valid(DI_valid), .DI_ready(DI_ready),
    .busy(busy), .cur_ch(cur_ch), .burst_done(burst_done)
  );

  always #5 ifclk = ~ifclk;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [16:0] pkt[4][64];
  int          head[4];
  int          tail[4];
  bit          rdy_rand = 0;
  bit          gap_en = 0;
  int          bd_cnt = 0;
  logic [1:0]  model_rr = 2'd3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic add_pkt(input int c, input int len, input logic [15:0] base, input bit rnd);
    for (int i = 0; i < len; i++) begin
      pkt[c][tail[c]] = {(i == len - 1), rnd ? 16'($urandom) : 16'(base + 16'(i))};
      tail[c]++;
    end
  endtask

  // Reference: repeatedly pick the next pending enabled channel after the last
  // winner, emit its header, then up to MB words or until a last flag.
  task automatic model_build(input logic [3:0] en, output int nb);
    int h[4];
    int ch;
    int n;
    bit found;
    logic [16:0] w;
    nb = 0;
    for (int c = 0; c < 4; c++) h[c] = head[c];
    forever begin
      found = 0;
      ch = 0;
      for (int i = 1; i <= 4; i++) begin
        int c;
        c = (int'(model_rr) + i) % 4;
        if (!found && en[c] && h[c] < tail[c]) begin
          found = 1;
          ch = c;
        end
      end
      if (!found) break;
      exp_q.push_back({HDR, 6'd0, 2'(ch)});
      n = 0;
      do begin
        w = pkt[ch][h[ch]];
        h[ch]++;
        exp_q.push_back(w[15:0]);
        n++;
      end while (!w[16] && n < MB);
      nb++;
      model_rr = 2'(ch);
    end
  endtask

  task automatic sync();
    @(negedge ifclk);
    #3;
  endtask

  task automatic start_phase(input logic [3:0] en, input bit rr, input bit gp, output int nb);
    ch_enable = en;
    rdy_rand  = rr;
    gap_en    = gp;
    bd_cnt    = 0;
    model_build(en, nb);
  endtask

  task automatic clear_sources();
    for (int c = 0; c < 4; c++) begin
      head[c] = 0;
      tail[c] = 0;
    end
  endtask

  task automatic finish_phase(input int nb, input string tag);
    int n;
    for (n = 0; n < 3000; n++) begin
      if (exp_q.size() == 0 && !busy && !DI_valid) break;
      sync();
    end
    check("drain_in_time", (n < 3000), 1'b1);
    repeat (2) @(negedge ifclk);
    #3;
    check("burst_count", bd_cnt, nb);
    check("busy_idle", busy, 1'b0);
    check("exp_empty", exp_q.size(), 0);
    $display("phase %s bursts=%0d", tag, bd_cnt);
    clear_sources();
  endtask

  // Source driver: each channel presents its packet words in order, holding valid
  // while data is pending, with optional gaps only during its own grant.
  initial begin
    logic [3:0] acc;
    forever begin
      @(negedge ifclk);
      DI_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (head[c] < tail[c] &&
            !(gap_en && busy && cur_ch == 2'(c) && $urandom_range(0, 3) == 0)) begin
          src_valid[c]         = 1'b1;
          src_data[16*c +: 16] = pkt[c][head[c]][15:0];
          src_last[c]          = pkt[c][head[c]][16];
        end else begin
          src_valid[c]         = 1'b0;
          src_data[16*c +: 16] = 16'h0000;
          src_last[c]          = 1'b0;
        end
      end
      #1 acc = src_valid & src_ready;
      @(posedge ifclk);
      if (reset_n) begin
        for (int c = 0; c < 4; c++) if (acc[c]) head[c]++;
      end
    end
  end

  // Monitor: protocol checks plus scoreboard pop on every DI transfer.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_di;
    logic [15:0] e;
    logic [3:0]  allowed;
    prev_stall = 1'b0;
    prev_di = 16'h0;
    forever begin
      @(negedge ifclk);
      #2;
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", DI_valid, 1'b1);
        check("hold_data", DI, prev_di);
      end
      allowed = busy ? (4'b0001 << cur_ch) : 4'b0000;
      check("ready_only_grant", src_ready & ~allowed, 4'b0000);
      if (DI_valid && !DI_ready) check("ready_in_stall", src_ready, 4'b0000);
      if (DI_valid && DI_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word actual=%h required=none", DI);
        end else begin
          e = exp_q.pop_front();
          $display("xfer DI=%h expected=%h", DI, e);
          check("di_word", DI, e);
        end
      end
      if (burst_done) bd_cnt++;
      prev_stall = DI_valid && !DI_ready;
      prev_di = DI;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    int n;
    logic [3:0] en;
    reset_n   = 1'b0;
    src_valid = 4'h0;
    src_last  = 4'h0;
    src_data  = 64'h0;
    ch_enable = 4'hF;
    DI_ready  = 1'b1;
    clear_sources();
    #2;
    check("rst_di", DI, 16'h0000);
    check("rst_di_valid", DI_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cur_ch", cur_ch, 2'd0);
    check("rst_burst_done", burst_done, 1'b0);
    check("rst_src_ready", src_ready, 4'h0);
    repeat (3) @(negedge ifclk);
    #3 reset_n = 1'b1;

    // Single 3-word packet on channel 0
    sync();
    add_pkt(0, 3, 16'h0001, 0);
    start_phase(4'hF, 0, 0, nb);
    finish_phase(nb, "basic");

    // Round robin across all channels
    sync();
    add_pkt(0, 1, 16'h1000, 0);
    add_pkt(0, 1, 16'h1001, 0);
    add_pkt(1, 1, 16'h1100, 0);
    add_pkt(2, 1, 16'h1200, 0);
    add_pkt(3, 1, 16'h1300, 0);
    start_phase(4'hF, 0, 0, nb);
    finish_phase(nb, "round_robin");

    // 10 words without intermediate last -> cut into 4+4+2
    sync();
    add_pkt(1, 10, 16'h2000, 0);
    start_phase(4'hF, 0, 0, nb);
    finish_phase(nb, "max_burst");

    // Backpressure and source gaps
    sync();
    add_pkt(2, 6, 16'h3000, 0);
    start_phase(4'hF, 1, 1, nb);
    finish_phase(nb, "stall");

    // Disabled channel 1 is never granted
    sync();
    add_pkt(1, 2, 16'h4100, 0);
    add_pkt(3, 2, 16'h4300, 0);
    start_phase(4'b1101, 0, 0, nb);
    finish_phase(nb, "disable");

    // Clearing the enable mid-burst still completes the burst
    sync();
    add_pkt(0, 3, 16'h5000, 0);
    start_phase(4'hF, 0, 0, nb);
    for (n = 0; n < 100; n++) begin
      if (busy && cur_ch == 2'd0) break;
      sync();
    end
    check("grant_seen", (n < 100), 1'b1);
    ch_enable = 4'b1110;
    finish_phase(nb, "enable_clear");

    // Randomized traffic
    for (int it = 0; it < 6; it++) begin
      sync();
      for (int c = 0; c < 4; c++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) add_pkt(c, $urandom_range(1, 7), 16'h0, 1);
      end
      en = 4'($urandom_range(1, 15));
      start_phase(en, 1, 1, nb);
      finish_phase(nb, "random");
    end

    // Asynchronous reset in the middle of a burst
    sync();
    add_pkt(0, 10, 16'h6000, 0);
    start_phase(4'hF, 0, 0, nb);
    for (n = 0; n < 100; n++) begin
      if (head[0] >= 2) break;
      sync();
    end
    check("reset_burst_started", (n < 100), 1'b1);
    reset_n = 1'b0;
    #1;
    check("async_rst_di_valid", DI_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_src_ready", src_ready, 4'h0);
    exp_q.delete();
    clear_sources();
    model_rr = 2'd3;
    sync();
    reset_n = 1'b1;
    sync();
    add_pkt(2, 1, 16'h7200, 0);
    add_pkt(1, 1, 16'h7100, 0);
    add_pkt(0, 1, 16'h7000, 0);
    add_pkt(3, 1, 16'h7300, 0);
    start_phase(4'hF, 0, 0, nb);
    finish_phase(nb, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
